// File: rtl/id_decode_queue.sv
// id_decode_queue: N-lane decode stage feeding a DEPTH-entry bundle FIFO.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   if_instr[LANES]         fetched bundle (lane 0 oldest)
//   if_valid / if_ready     bundle handshake from fetch
//   dec_instr[LANES]        decoded head bundle ('0 when empty)
//   dec_valid / dec_ready   head handshake toward issue
//   flush                   synchronous discard of all bundles
//   occupancy               stored bundle count
// Build option: ID_COMPACT_EN packs valid lanes toward lane 0.

package id_decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_type;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src;
        logic        illegal;
    } control_type;

endpackage

module control_unit
    import id_decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  if_id_type   if_instr,
    output control_type ctrl
);

    // Clock/reset ports keep the lane interface uniform; decode itself
    // is purely combinational.
    logic unused_ports;
    assign unused_ports = clk ^ reset_n;

    logic [31:0] w;
    logic [6:0]  op;
    assign w  = if_instr.instr;
    assign op = w[6:0];

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{w[31]}}, w[31:20]};
    assign imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
    assign imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    assign imm_u = {w[31:12], 12'b0};
    assign imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};

    always_comb begin
        ctrl        = '0;
        ctrl.pc     = if_instr.pc;
        ctrl.rd     = w[11:7];
        ctrl.rs1    = w[19:15];
        ctrl.rs2    = w[24:20];
        ctrl.funct3 = w[14:12];
        unique case (1'b1)
            (op == OP_LUI), (op == OP_AUIPC): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm       = imm_u;
            end
            (op == OP_JAL): begin
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.imm       = imm_j;
            end
            (op == OP_JALR): begin
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm       = imm_i;
            end
            (op == OP_BRANCH): begin
                ctrl.branch = 1'b1;
                ctrl.imm    = imm_b;
            end
            (op == OP_LOAD): begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm       = imm_i;
            end
            (op == OP_STORE): begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm       = imm_s;
            end
            (op == OP_IMM): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm       = imm_i;
            end
            (op == OP_REG): begin
                ctrl.reg_write = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

module id_decode_queue
    import id_decode_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  if_id_type                  if_instr [LANES],
    input  logic [LANES-1:0]           if_valid,
    output logic                       if_ready,
    output control_type                dec_instr [LANES],
    output logic [LANES-1:0]           dec_valid,
    input  logic                       dec_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    control_type      dec_lane [LANES];
    control_type      st_instr [LANES];
    logic [LANES-1:0] st_mask;

    control_type      mem      [DEPTH][LANES];
    logic [LANES-1:0] mem_mask [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [OW-1:0] occ;
    logic          enq;
    logic          deq;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        control_unit u_cu (
            .clk      (clk),
            .reset_n  (reset_n),
            .if_instr (if_instr[i]),
            .ctrl     (dec_lane[i])
        );
    end

`ifdef ID_COMPACT_EN
    // Valid lane i lands in slot cnt, where cnt counts valid lanes
    // below it; this keeps program order and yields a contiguous mask.
    always_comb begin
        int cnt;
        for (int j = 0; j < LANES; j++) begin
            st_instr[j] = '0;
        end
        st_mask = '0;
        cnt     = 0;
        for (int i = 0; i < LANES; i++) begin
            if (if_valid[i]) begin
                for (int j = 0; j < LANES; j++) begin
                    if (cnt == j) begin
                        st_instr[j] = dec_lane[i];
                    end
                end
                cnt = cnt + 1;
            end
        end
        for (int j = 0; j < LANES; j++) begin
            st_mask[j] = (cnt > j);
        end
    end
`else
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            st_instr[j] = dec_lane[j];
        end
        st_mask = if_valid;
    end
`endif

    assign if_ready  = (occ != FULL);
    assign occupancy = occ;
    assign enq = if_ready & (|if_valid) & ~flush;
    assign deq = dec_ready & (|dec_valid) & ~flush;

    // Head is masked by occupancy so stale storage never leaks out.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            dec_instr[j] = '0;
        end
        dec_valid = '0;
        if (occ != '0) begin
            for (int j = 0; j < LANES; j++) begin
                dec_instr[j] = mem[rd_ptr][j];
            end
            dec_valid = mem_mask[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                mem_mask[d] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (enq) begin
                mem_mask[wr_ptr] <= st_mask;
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            unique case ({enq, deq})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Lane payload needs no reset: it is only visible under a valid mask.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int j = 0; j < LANES; j++) begin
                mem[wr_ptr][j] <= st_instr[j];
            end
        end
    end

endmodule

// File: tb/tb_id_decode_queue.sv
// Bench for id_decode_queue: random bundles checked against a queue model
// and an independent RV32 decode reference.

module tb_id_decode_queue;
    import id_decode_pkg::*;

    localparam int LANES = 2;
    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH + 1);
`ifdef ID_COMPACT_EN
    localparam bit COMPACT = 1'b1;
`else
    localparam bit COMPACT = 1'b0;
`endif

    typedef struct packed {
        logic [LANES-1:0]              mask;
        control_type [LANES-1:0]       lane;
    } bund_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    if_id_type        if_instr [LANES];
    logic [LANES-1:0] if_valid = '0;
    logic             if_ready;
    control_type      dec_instr [LANES];
    logic [LANES-1:0] dec_valid;
    logic             dec_ready = 1'b0;
    logic             flush = 1'b0;
    logic [OW-1:0]    occupancy;

    bund_t q[$];
    bund_t last;
    int    vectors = 0;
    int    errors  = 0;

    always #5 clk = ~clk;

    id_decode_queue #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_instr  (if_instr),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .dec_instr (dec_instr),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .flush     (flush),
        .occupancy (occupancy)
    );

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic [31:0] t;
        t = v & ((32'd1 << bits) - 32'd1);
        if (t >= (32'd1 << (bits - 1))) t = t - (32'd1 << bits);
        return t;
    endfunction

    function automatic control_type ref_decode(input if_id_type x);
        control_type r;
        logic [31:0] i;
        i = x.instr;
        r = '0;
        r.pc = x.pc;
        r.rd = i[11:7];
        r.rs1 = i[19:15];
        r.rs2 = i[24:20];
        r.funct3 = i[14:12];
        case (i[6:0])
            7'h37, 7'h17: begin
                r.reg_write = 1; r.alu_src = 1;
                r.imm = {i[31:12], 12'h000};
            end
            7'h6f: begin
                r.reg_write = 1; r.jump = 1;
                r.imm = sext({i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
            end
            7'h67: begin
                r.reg_write = 1; r.jump = 1; r.alu_src = 1;
                r.imm = sext({20'h0, i[31:20]}, 12);
            end
            7'h63: begin
                r.branch = 1;
                r.imm = sext({i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
            end
            7'h03: begin
                r.reg_write = 1; r.mem_read = 1; r.alu_src = 1;
                r.imm = sext({20'h0, i[31:20]}, 12);
            end
            7'h23: begin
                r.mem_write = 1; r.alu_src = 1;
                r.imm = sext({20'h0, i[31:25], i[11:7]}, 12);
            end
            7'h13: begin
                r.reg_write = 1; r.alu_src = 1;
                r.imm = sext({20'h0, i[31:20]}, 12);
            end
            7'h33: r.reg_write = 1;
            default: r.illegal = 1;
        endcase
        return r;
    endfunction

    // What the queue should hold for the bundle currently presented.
    function automatic bund_t model_store();
        bund_t b;
        int k;
        b = '0;
        k = 0;
        for (int i = 0; i < LANES; i++) begin
            if (COMPACT) begin
                if (if_valid[i]) begin
                    b.lane[k] = ref_decode(if_instr[i]);
                    b.mask[k] = 1'b1;
                    k++;
                end
            end else begin
                b.lane[i] = ref_decode(if_instr[i]);
            end
        end
        if (!COMPACT) b.mask = if_valid;
        return b;
    endfunction

    task automatic rand_instrs();
        logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
                                7'h03, 7'h23, 7'h13, 7'h33};
        logic [31:0] w;
        int k;
        for (int i = 0; i < LANES; i++) begin
            w = $urandom();
            k = $urandom_range(0, 9);
            if (k < 9) w[6:0] = ops[k];
            if_instr[i].instr = w;
            if_instr[i].pc = $urandom();
        end
    endtask

    // Drive one cycle, advance the model across the edge, land at edge+1.
    task automatic cycle(input logic [LANES-1:0] m, input logic r, input logic f);
        bit e, d;
        rand_instrs();
        if_valid = m;
        dec_ready = r;
        flush = f;
        last = model_store();
        e = (q.size() < DEPTH) && (m != '0) && !f;
        d = r && (q.size() > 0) && !f;
        @(posedge clk);
        if (f) begin
            q.delete();
        end else begin
            if (d) void'(q.pop_front());
            if (e) q.push_back(last);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < LANES; i++) if_instr[i] = '0;
        #12 reset_n = 1'b1;
        #1;
        vectors++;
        if (if_ready !== 1'b1) begin
            errors++; $display("FAIL reset_if_ready got %b want 1", if_ready);
        end
        vectors++;
        if (occupancy !== '0) begin
            errors++; $display("FAIL reset_occ got %0d want 0", occupancy);
        end
        vectors++;
        if (dec_valid !== '0) begin
            errors++; $display("FAIL reset_dec_valid got %b want 00", dec_valid);
        end
        for (int l = 0; l < LANES; l++) begin
            vectors++;
            if (dec_instr[l] !== '0) begin
                errors++; $display("FAIL reset_dec_instr%0d got %h want 0", l, dec_instr[l]);
            end
        end
    endtask

    task automatic test_fill();
        int want;
        for (int n = 1; n <= DEPTH + 1; n++) begin
            cycle(2'b11, 1'b0, 1'b0);
            want = (n < DEPTH) ? n : DEPTH;
            vectors++;
            if (occupancy !== OW'(want)) begin
                errors++; $display("FAIL fill_occ got %0d want %0d", occupancy, want);
            end
            vectors++;
            if (if_ready !== (want < DEPTH)) begin
                errors++; $display("FAIL fill_if_ready got %b want %b", if_ready, want < DEPTH);
            end
        end
        for (int n = 0; n < DEPTH; n++) begin
            vectors++;
            if (dec_valid !== q[0].mask) begin
                errors++; $display("FAIL drain_valid got %b want %b", dec_valid, q[0].mask);
            end
            for (int l = 0; l < LANES; l++) begin
                vectors++;
                if (dec_instr[l] !== q[0].lane[l]) begin
                    errors++; $display("FAIL drain_lane%0d got %h want %h", l, dec_instr[l], q[0].lane[l]);
                end
            end
            cycle(2'b00, 1'b1, 1'b0);
        end
        vectors++;
        if (occupancy !== '0) begin
            errors++; $display("FAIL drain_occ got %0d want 0", occupancy);
        end
    endtask

    task automatic test_stream();
        for (int n = 0; n < 10; n++) begin
            cycle(2'b11, 1'b1, 1'b0);
            vectors++;
            if (occupancy !== OW'(1)) begin
                errors++; $display("FAIL stream_occ got %0d want 1", occupancy);
            end
            for (int l = 0; l < LANES; l++) begin
                vectors++;
                if (dec_instr[l] !== last.lane[l]) begin
                    errors++; $display("FAIL stream_lane%0d got %h want %h", l, dec_instr[l], last.lane[l]);
                end
            end
        end
        cycle(2'b00, 1'b1, 1'b0);
        vectors++;
        if (occupancy !== '0 || dec_valid !== '0) begin
            errors++; $display("FAIL stream_end got occ %0d valid %b want 0 00", occupancy, dec_valid);
        end
    endtask

    task automatic test_flush();
        for (int n = 0; n < 3; n++) cycle(2'b11, 1'b0, 1'b0);
        vectors++;
        if (occupancy !== OW'(3)) begin
            errors++; $display("FAIL flush_pre_occ got %0d want 3", occupancy);
        end
        cycle(2'b11, 1'b1, 1'b1);
        vectors++;
        if (occupancy !== '0) begin
            errors++; $display("FAIL flush_occ got %0d want 0", occupancy);
        end
        vectors++;
        if (dec_valid !== '0) begin
            errors++; $display("FAIL flush_valid got %b want 00", dec_valid);
        end
        vectors++;
        if (if_ready !== 1'b1) begin
            errors++; $display("FAIL flush_if_ready got %b want 1", if_ready);
        end
        cycle(2'b00, 1'b0, 1'b0);
        vectors++;
        if (occupancy !== '0 || dec_valid !== '0) begin
            errors++; $display("FAIL flush_after got occ %0d valid %b want 0 00", occupancy, dec_valid);
        end
    endtask

    task automatic test_sparse();
        logic [LANES-1:0] want;
        control_type exp1;
        int slot;
        cycle(2'b10, 1'b0, 1'b0);
        exp1 = ref_decode(if_instr[1]);
        want = COMPACT ? 2'b01 : 2'b10;
        slot = COMPACT ? 0 : 1;
        vectors++;
        if (dec_valid !== want) begin
            errors++; $display("FAIL sparse_valid got %b want %b", dec_valid, want);
        end
        vectors++;
        if (dec_instr[slot] !== exp1) begin
            errors++; $display("FAIL sparse_lane got %h want %h", dec_instr[slot], exp1);
        end
        cycle(2'b00, 1'b0, 1'b0);
        vectors++;
        if (occupancy !== OW'(1)) begin
            errors++; $display("FAIL zero_mask_occ got %0d want 1", occupancy);
        end
        cycle(2'b00, 1'b1, 1'b0);
        vectors++;
        if (occupancy !== '0) begin
            errors++; $display("FAIL sparse_drain got %0d want 0", occupancy);
        end
    endtask

    task automatic test_random();
        logic [LANES-1:0] m, wv;
        for (int n = 0; n < 400; n++) begin
            m = LANES'($urandom_range(0, 3));
            cycle(m, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
            vectors++;
            if (occupancy !== OW'(q.size())) begin
                errors++; $display("FAIL rand_occ got %0d want %0d", occupancy, q.size());
            end
            vectors++;
            if (if_ready !== (q.size() < DEPTH)) begin
                errors++; $display("FAIL rand_if_ready got %b want %b", if_ready, q.size() < DEPTH);
            end
            wv = (q.size() > 0) ? q[0].mask : '0;
            vectors++;
            if (dec_valid !== wv) begin
                errors++; $display("FAIL rand_valid got %b want %b", dec_valid, wv);
            end
            if (q.size() > 0) begin
                for (int l = 0; l < LANES; l++) begin
                    if (!COMPACT || q[0].mask[l]) begin
                        vectors++;
                        if (dec_instr[l] !== q[0].lane[l]) begin
                            errors++; $display("FAIL rand_lane%0d got %h want %h", l, dec_instr[l], q[0].lane[l]);
                        end
                    end
                end
            end
        end
        while (q.size() > 0) cycle(2'b00, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b0);
        if_valid = '0;
        dec_ready = 1'b0;
        vectors++;
        if (occupancy !== OW'(2)) begin
            errors++; $display("FAIL areset_pre_occ got %0d want 2", occupancy);
        end
        #3 reset_n = 1'b0;
        #1;
        q.delete();
        vectors++;
        if (dec_valid !== '0) begin
            errors++; $display("FAIL areset_valid got %b want 00", dec_valid);
        end
        vectors++;
        if (occupancy !== '0) begin
            errors++; $display("FAIL areset_occ got %0d want 0", occupancy);
        end
        vectors++;
        if (if_ready !== 1'b1) begin
            errors++; $display("FAIL areset_if_ready got %b want 1", if_ready);
        end
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (occupancy !== '0) begin
            errors++; $display("FAIL areset_post_occ got %0d want 0", occupancy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_flush();
        test_sparse();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
